// File: rtl/fifo_burst_reader.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream framed into BURST_LEN bursts.
// A 3-entry prefetch buffer keeps 1 word/clk; read strobe depends only on registered state, enable and empty.
module fifo_burst_reader #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  output logic              o_fifo_rd_en,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic [CNT_W-1:0]  o_burst_cnt
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [DATA_W-1:0] buf_q [3];
  logic [DATA_W-1:0] buf_d [3];
  logic [1:0]        occ_q, occ_d, occ_pop;
  logic              inflight_q;
  logic [BW-1:0]     beat_q, beat_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic              hs;

  // occ + inflight counts every word already committed to the buffer; cap at 3.
  assign o_fifo_rd_en = !rst && i_enable && !i_fifo_empty &&
                        (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
  assign o_valid      = (occ_q != 2'd0);
  assign o_data       = buf_q[0];
  assign o_last       = o_valid && (beat_q == LAST_BEAT);
  assign o_burst_cnt  = burst_q;
  assign hs           = o_valid && i_ready;

  always_comb begin
    buf_d   = buf_q;
    occ_pop = occ_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    if (hs) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
      occ_pop  = occ_q - 2'd1;
      if (beat_q == LAST_BEAT) begin
        beat_d  = '0;
        burst_d = burst_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
    occ_d = occ_pop;
    // Returning word lands behind whatever survives this cycle's pop.
    if (inflight_q) begin
      case (occ_pop)
        2'd0:    buf_d[0] = i_fifo_data;
        2'd1:    buf_d[1] = i_fifo_data;
        default: buf_d[2] = i_fifo_data;
      endcase
      occ_d = occ_pop + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      burst_q    <= '0;
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= o_fifo_rd_en;
      beat_q     <= beat_d;
      burst_q    <= burst_d;
      buf_q      <= buf_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader: queue-based FIFO and stream model, per-cycle compare.
module tb_fifo_burst_reader;
  localparam int DW = 64;
  localparam int BL = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_enable = 1'b1;
  logic          o_fifo_rd_en;
  logic          i_fifo_empty = 1'b1;
  logic [DW-1:0] i_fifo_data = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic [CW-1:0] o_burst_cnt;

  fifo_burst_reader #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .o_fifo_rd_en(o_fifo_rd_en),
    .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_last(o_last), .o_burst_cnt(o_burst_cnt)
  );

  always #5 clk = ~clk;

  // FIFO contents, words owned by the reader (buffered, FIFO order), and bookkeeping
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sent[$];
  logic [DW-1:0] got[$];
  int            got_last[$];
  bit            m_inflight = 0;
  int            hs_total = 0;
  int            n_chk = 0, n_fail = 0;
  int            n_rd, n_hs, cyc, first_rd, first_vld, hs_first, hs_last;
  logic [DW-1:0] next_fd;
  logic          pv = 0, pr = 0, pl = 0, prst = 1;
  logic [DW-1:0] pd = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    n_rd = 0; n_hs = 0; cyc = 0; first_rd = -1; first_vld = -1; hs_first = -1; hs_last = -1;
    got.delete(); got_last.delete(); sent.delete();
  endtask

  task automatic load(input int n, input bit rand_data);
    logic [DW-1:0] w;
    for (int i = 1; i <= n; i++) begin
      w = rand_data ? {$urandom, $urandom} : DW'(i);
      fifo.push_back(w);
      sent.push_back(w);
    end
  endtask

  // One clock: called at a negedge with rst/i_enable/i_ready already set.
  task automatic step();
    bit exp_rd, exp_v, hs;
    i_fifo_empty = (fifo.size() == 0);
    #1;
    exp_rd = !rst && i_enable && (fifo.size() != 0) && ((mq.size() + int'(m_inflight)) < 3);
    exp_v  = (mq.size() != 0);
    check("rd_en", o_fifo_rd_en, exp_rd);
    check("valid", o_valid, exp_v);
    check("last", o_last, exp_v && (hs_total % BL == BL - 1));
    check("burst_cnt", o_burst_cnt, DW'((hs_total / BL) % (1 << CW)));
    if (exp_v) check("data", o_data, mq[0]);
    if (pv && !pr && !prst) begin
      check("stall_valid", o_valid, 1);
      check("stall_data", o_data, pd);
      check("stall_last", o_last, pl);
    end
    pv = o_valid; pd = o_data; pl = o_last; pr = i_ready; prst = rst;
    if (o_fifo_rd_en && first_rd < 0) first_rd = cyc;
    if (o_valid && first_vld < 0) first_vld = cyc;
    hs = exp_v && i_ready;
    if (rst) begin
      mq.delete();
      m_inflight = 0;
      hs_total = 0;
    end else begin
      if (hs) begin
        got.push_back(mq[0]);
        if (hs_total % BL == BL - 1) got_last.push_back(n_hs);
        void'(mq.pop_front());
        hs_total++;
        n_hs++;
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
      end
      if (m_inflight) mq.push_back(i_fifo_data);
      m_inflight = exp_rd;
    end
    if (exp_rd) begin
      next_fd = fifo.pop_front();
      n_rd++;
    end else begin
      next_fd = {$urandom, $urandom};
    end
    @(posedge clk);
    @(negedge clk);
    i_fifo_data = next_fd;
    cyc++;
  endtask

  task automatic reset_dut();
    fifo.delete();
    rst = 1; i_ready = 1;
    step();
    rst = 0;
    clear_stats();
  endtask

  task automatic run_until(input int target, input int budget, input bit rnd_ready);
    int k = 0;
    while (n_hs < target && k < budget) begin
      i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      k++;
    end
    check("hs_budget", DW'(n_hs >= target), 1);
  endtask

  initial begin
    // Establish defined state with one unchecked reset edge
    @(posedge clk);
    @(negedge clk);
    clear_stats();

    // 1: reset held 2 clocks with a loaded FIFO
    load(10, 1);
    rst = 1; i_enable = 1; i_ready = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_data_zero", o_data, 0);
    end
    check("rst_no_reads", n_rd, 0);

    // 2: back-to-back stream of 1..256
    reset_dut();
    load(256, 0);
    run_until(256, 400, 0);
    for (int i = 0; i < 6; i++) step();
    check("s_reads", n_rd, 256);
    check("s_beats", n_hs, 256);
    check("s_bursts", o_burst_cnt, 16);
    check("s_lasts", got_last.size(), 16);
    if (got_last.size() == 16) check("s_last_idx", got_last[15], 255);
    // steps sample before each edge: read sampled at edge k, valid visible after edge k+1
    check("s_first_valid", first_vld, first_rd + 2);
    check("s_back2back", hs_last - hs_first, 255);
    for (int i = 0; i < got.size(); i++) check("s_word", got[i], DW'(i + 1));

    // 3: random backpressure, random data
    reset_dut();
    load(256, 1);
    run_until(256, 3000, 1);
    i_ready = 1;
    for (int i = 0; i < 6; i++) step();
    check("b_count", got.size(), 256);
    for (int i = 0; i < got.size() && i < sent.size(); i++) check("b_order", got[i], sent[i]);
    check("b_bursts", o_burst_cnt, 16);

    // 4: single word then empty
    reset_dut();
    fifo.push_back(64'hA5);
    for (int i = 0; i < 10; i++) step();
    check("e_reads", n_rd, 1);
    check("e_beats", n_hs, 1);
    if (got.size() > 0) check("e_word", got[0], 64'hA5);

    // 5: enable drop after 5th handshake, then resume mid-burst
    reset_dut();
    load(40, 0);
    run_until(5, 20, 0);
    i_enable = 0;
    for (int i = 0; i < 8; i++) step();
    check("d_rd_stop", o_fifo_rd_en, 0);
    check("d_drained", o_valid, 0);
    check("d_all_delivered", n_hs, n_rd);
    i_enable = 1;
    run_until(16, 40, 0);
    check("d_last_16th", got_last.size() > 0 ? got_last[0] : -1, 15);
    for (int i = 0; i < got.size(); i++) check("d_word", got[i], DW'(i + 1));

    // 6: reset during beat 7 with two words buffered
    reset_dut();
    load(100, 0);
    run_until(6, 20, 0);
    for (int k = 0; k < 5 && mq.size() != 2; k++) begin
      i_ready = 0;
      step();
    end
    check("m_occ2", mq.size(), 2);
    rst = 1; i_ready = 1;
    step();
    rst = 0;
    #1;
    check("m_valid_cleared", o_valid, 0);
    check("m_burst_cleared", o_burst_cnt, 0);
    clear_stats();
    run_until(16, 40, 0);
    check("m_last_16th", got_last.size() > 0 ? got_last[0] : -1, 15);
    check("m_bursts", o_burst_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
